// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared constants and the stage-1 record for add_pipe32.
//   WIDTH_DEF : default operand/sum width
//   HALF      : width of each half-adder stage (matches cla16)
//   s1_rec_t  : contents latched by stage 1 (low sum, low-half carry,
//               and the upper operand halves that stage 2 still needs)
package add_pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int HALF      = WIDTH_DEF / 2;

  typedef struct packed {
    logic [HALF-1:0] lo_sum;
    logic            c_half;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
  } s1_rec_t;

endpackage

// File: rtl/cla16.sv
// cla16: combinational 16-bit two-level carry-lookahead adder.
//   a, b : 16-bit operands
//   cin  : carry-in
//   sum  : a + b + cin (low 16 bits)
//   cout : carry out of bit 15
// Four 4-bit groups each produce group generate/propagate; the group
// carries are formed in one lookahead level, then the in-group carries.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;

    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end

    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

// File: rtl/add_pipe32.sv
// add_pipe32: two-stage pipelined adder with valid/ready on both sides.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid / in_ready : operand beat handshake (a, b, cin)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
//   sum  = a + b + cin mod 2^WIDTH, cout = carry out of MSB,
//   ovf  = signed overflow.
// Stage 1 adds the low half (plus cin); stage 2 adds the upper half plus
// the registered low-half carry. WIDTH must equal 2*HALF from the package,
// since each half is computed by one cla16.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both high; the producer holds the beat and its valid
// until that happens, and ready may depend combinationally on the
// consumer's ready.
module add_pipe32
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  s1_rec_t          s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout;
  logic             s2_ovf;

  logic [HALF-1:0]  lo_sum;
  logic             lo_cout;
  logic [HALF-1:0]  hi_sum;
  logic             hi_cout;
  logic             hi_ovf;
  logic             s2_adv;

  cla16 u_cla_lo (
    .a    (a[HALF-1:0]),
    .b    (b[HALF-1:0]),
    .cin  (cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla16 u_cla_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .cin  (s1_q.c_half),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Overflow: operands agree in sign but the result sign differs.
  assign hi_ovf = (s1_q.a_hi[HALF-1] == s1_q.b_hi[HALF-1]) &&
                  (hi_sum[HALF-1] != s1_q.a_hi[HALF-1]);

  // Stage 2 can take new contents when empty or when its result leaves now.
  assign s2_adv   = !s2_valid || out_ready;
  // Stage 1 can take new contents when empty or when it moves into stage 2.
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        s1_q.lo_sum <= lo_sum;
        s1_q.c_half <= lo_cout;
        s1_q.a_hi   <= a[WIDTH-1:HALF];
        s1_q.b_hi   <= b[WIDTH-1:HALF];
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid) begin
        s2_sum  <= {hi_sum, s1_q.lo_sum};
        s2_cout <= hi_cout;
        s2_ovf  <= hi_ovf;
      end
    end
  end

  // Result fields read zero whenever no beat is being offered.
  assign out_valid = s2_valid;
  assign sum       = s2_valid ? s2_sum : '0;
  assign cout      = s2_valid & s2_cout;
  assign ovf       = s2_valid & s2_ovf;

endmodule

// File: tb/tb_add_pipe32.sv
module tb_add_pipe32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  bit sending;

  // {ovf, cout, sum} of each accepted beat, oldest first
  logic [W+1:0] exp_q[$];

  add_pipe32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(out_valid), 64'(0));
        end else begin
          check("sum",  64'(sum),  64'(exp_q[0][W-1:0]));
          check("cout", 64'(cout), 64'(exp_q[0][W]));
          check("ovf",  64'(ovf),  64'(exp_q[0][W+1]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_zero", 64'({ovf, cout, sum}), 64'(0));
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc);
    bit done;
    int n;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'(done), 64'(1));
  endtask

  // Pipeline must be empty with out_ready high.
  task automatic directed(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tc,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_sum"},   64'(sum),       64'(es));
    check({tag, "_cout"},  64'(cout),      64'(ec));
    check({tag, "_ovf"},   64'(ovf),       64'(eo));
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b1; sending = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_outputs",   64'({ovf, cout, sum}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    directed("one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0,
             32'h0000_0002, 1'b0, 1'b0);
    directed("carry_out",    32'hFFFF_0006, 32'h1256_0006, 1'b0,
             32'h1255_000C, 1'b1, 1'b0);
    directed("cross_stage",  32'h0000_FFFF, 32'h0000_0001, 1'b0,
             32'h0001_0000, 1'b0, 1'b0);
    directed("pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
    directed("wrap_cin",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
             32'h0000_0000, 1'b1, 1'b0);
    directed("neg_ovf",      32'h8000_0000, 32'h8000_0000, 1'b0,
             32'h0000_0000, 1'b1, 1'b1);

    // Backpressure: two beats fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    send(32'h1000_0001, 32'h2000_0002, 1'b0);
    send(32'h3000_FFFF, 32'h0000_0001, 1'b1);
    a = 32'h0ABC_DEF0; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  64'(in_ready),  64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      step();
    end
    out_ready = 1'b1;
    send(32'h0ABC_DEF0, 32'h1111_1111, 1'b0);
    send(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    drain();

    // Random back-to-back stream with random consumer stalls.
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          send($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        sending = 1'b0;
      end
      begin
        while (sending) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    send(32'h1234_5678, 32'h8765_4321, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_outputs",   64'({ovf, cout, sum}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_quiet", 64'(out_valid), 64'(0));
    end
    directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0,
             32'h2345_6789, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
